// File: rtl/nx_fifo_wr_arb.sv
// Round-robin write-port arbiter and flush sequencer in front of a shared nx_fifo.
// Optional per-requester grant counters: define NX_FIFO_WR_ARB_STATS_EN.
module nx_fifo_wr_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 96,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    flush_req,
    output logic                    flush_done,
    input  logic                    fifo_full,
    input  logic                    fifo_empty,
    output logic                    fifo_wen,
    output logic [WIDTH-1:0]        fifo_wdata,
    output logic                    fifo_clear,
    output logic [IDW-1:0]          grant_id,
    output logic                    busy
`ifdef NX_FIFO_WR_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]      grant_cnt
`endif
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        CLR   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand_idx;
    int unsigned    cand;
    logic           found;
    logic           arb_open;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(last_grant) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!found && req_valid[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // Zero-latency write path; gated by rst so everything reads 0 during reset.
    always_comb begin
        arb_open   = !rst && (state == ARB) && !flush_req && !fifo_full && found;
        req_ready  = '0;
        req_ready[winner] = arb_open;
        fifo_wen   = arb_open;
        fifo_wdata = arb_open ? req_data[32'(winner)*WIDTH +: WIDTH] : '0;
    end

    // Flush sequencer and pointer state; clear/done/busy are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            last_grant <= IDW'(NREQ - 1);
            grant_id   <= '0;
            fifo_clear <= 1'b0;
            flush_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            fifo_clear <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                ARB: begin
                    if (flush_req) begin
                        state      <= CLR;
                        fifo_clear <= 1'b1;
                        busy       <= 1'b1;
                    end else if (arb_open) begin
                        last_grant <= winner;
                        grant_id   <= winner;
                    end
                end
                CLR: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];

    // Saturating per-requester accept counters, wiped when the FIFO is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else if (state == CLR) begin
            for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (arb_open && (winner == IDW'(i)) && (cnt_q[i] != 16'hFFFF))
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Randomized self-checking bench for nx_fifo_wr_arb against a cycle-level reference model.
module tb_nx_fifo_wr_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 96;
    localparam int unsigned IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  flush_req;
    logic                  flush_done;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_wen;
    logic [WIDTH-1:0]      fifo_wdata;
    logic                  fifo_clear;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
`ifdef NX_FIFO_WR_ARB_STATS_EN
    logic [NREQ*16-1:0]    grant_cnt;
`endif

    logic [WIDTH-1:0] d [NREQ];
    assign req_data = {d[3], d[2], d[1], d[0]};

    nx_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .fifo_wen   (fifo_wen),
        .fifo_wdata (fifo_wdata),
        .fifo_clear (fifo_clear),
        .grant_id   (grant_id),
        .busy       (busy)
`ifdef NX_FIFO_WR_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = arbitrating, 1 = clearing, 2 = waiting for empty, 3 = done pulse.
    int          m_last;
    int          m_phase;
    int          m_gid;
    int          m_cnt [NREQ];
    logic [3:0]  last_acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last   = NREQ - 1;
        m_phase  = 0;
        m_gid    = 0;
        last_acc = '0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    // Producers refresh data only when their previous word was taken or they were idle.
    task automatic drive(input logic [3:0] v, input logic full, input logic fl, input logic emp);
        for (int i = 0; i < NREQ; i++)
            if (!(req_valid[i] && !last_acc[i])) d[i] = {$urandom, $urandom, $urandom};
        req_valid  = v;
        fifo_full  = full;
        flush_req  = fl;
        fifo_empty = emp;
    endtask

    // One clock: compare all outputs with the model, then advance the model over the edge.
    task automatic step();
        logic [3:0]       er;
        logic [WIDTH-1:0] ed;
        int               win;
        bit               open;
        #1;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (win < 0 && req_valid[j]) win = j;
        end
        open = (m_phase == 0) && !flush_req && !fifo_full && (win >= 0);
        er   = open ? 4'(1 << win) : 4'b0;
        ed   = open ? d[win] : '0;
        check("ready", req_ready, er);
        check("wen", fifo_wen, open);
        check("wdata", fifo_wdata, ed);
        check("clear", fifo_clear, m_phase == 1);
        check("done", flush_done, m_phase == 3);
        check("busy", busy, m_phase != 0);
        check("grant_id", grant_id, m_gid);
`ifdef NX_FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
        @(posedge clk);
        last_acc = req_valid & er;
        case (m_phase)
            0: begin
                if (flush_req) m_phase = 1;
                else if (open) begin
                    m_last = win;
                    m_gid  = win;
                    if (m_cnt[win] < 65535) m_cnt[win]++;
                end
            end
            1: begin
                m_phase = 2;
                for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
            end
            2: if (fifo_empty) m_phase = 3;
            default: m_phase = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {req_ready, fifo_wen, fifo_clear, flush_done, busy, grant_id}, '0);
        check(tag, fifo_wdata, '0);
`ifdef NX_FIFO_WR_ARB_STATS_EN
        check(tag, grant_cnt, '0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) d[i] = '0;
        req_valid = 4'hF; fifo_full = 1'b0; flush_req = 1'b0; fifo_empty = 1'b1;
        model_reset();
        #1 check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Continuous full-valid traffic rotates 0,1,2,3,...
        for (int i = 0; i < 8; i++) begin
            drive(4'hF, 1'b0, 1'b0, 1'b0);
            #1 check("t1_order", req_ready, 4'(4'b0001 << (i % 4)));
            check("t1_wen", fifo_wen, 1'b1);
            step();
        end

        // Only 1 and 3 requesting.
        for (int i = 0; i < 6; i++) begin
            drive(4'b1010, 1'b0, 1'b0, 1'b0);
            #1 check("t2_skip", req_ready & 4'b0101, 4'b0);
            step();
        end

        // FIFO full stalls everything, then resumes without skipping.
        drive(4'hF, 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            drive(4'hF, 1'b1, 1'b0, 1'b0);
            #1 check("t3_full", {req_ready, fifo_wen}, 5'b0);
            step();
        end
        for (int i = 0; i < 4; i++) begin drive(4'hF, 1'b0, 1'b0, 1'b0); step(); end

        // Flush during traffic: empty rises two cycles after clear, done three cycles after.
        drive(4'hF, 1'b0, 1'b1, 1'b0);
        #1 check("t4_nowrite", fifo_wen, 1'b0);
        step();
        drive(4'hF, 1'b0, 1'b0, 1'b0);
        #1 check("t4_clear", fifo_clear, 1'b1);
        step();
        step();
        drive(4'hF, 1'b0, 1'b0, 1'b1);
        step();
        #1 check("t4_done", flush_done, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin drive(4'hF, 1'b0, 1'b0, 1'b0); step(); end

        // Reset while waiting for the FIFO to drain.
        drive(4'hF, 1'b0, 1'b1, 1'b0); step();
        drive(4'hF, 1'b0, 1'b0, 1'b0); step();
        step();
        #1 rst = 1'b1;
        #1 check_all_zero("t5_async");
        @(negedge clk);
        check_all_zero("t5_hold");
        rst = 1'b0;
        model_reset();
        drive(4'hF, 1'b0, 1'b0, 1'b0);
        #1 check("t5_first", req_ready, 4'b0001);
        step();
        for (int i = 0; i < 3; i++) begin drive(4'hF, 1'b0, 1'b0, 1'b0); step(); end

`ifdef NX_FIFO_WR_ARB_STATS_EN
        // Counter for requester 2 counts transfers and is wiped by a flush.
        drive(4'b0000, 1'b0, 1'b1, 1'b1); step();
        drive(4'b0000, 1'b0, 1'b0, 1'b1); step();
        step(); step();
        for (int i = 0; i < 5; i++) begin drive(4'b0100, 1'b0, 1'b0, 1'b0); step(); end
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        #1 check("t6_cnt5", grant_cnt[2*16 +: 16], 16'd5);
        step();
        drive(4'b0000, 1'b0, 1'b0, 1'b0); step();
        #1 check("t6_cnt0", grant_cnt[2*16 +: 16], 16'd0);
        drive(4'b0000, 1'b0, 1'b0, 1'b1); step();
        step();
`endif

        // Randomized traffic with stalls and flushes; pending words stay valid until taken.
        for (int c = 0; c < 500; c++) begin
            logic [3:0] v;
            v = 4'($urandom) | (req_valid & ~last_acc);
            drive(v, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4,
                  1'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
